// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller with zero-wait read hits.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_controller #(
  parameter int INDEX_BITS = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_r_en,
  input  logic        cpu_w_en,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_r_en,
  output logic        mem_w_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 12 - INDEX_BITS;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM, DONE} state_t;

  state_t state, state_nxt;

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      rdata_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic                  waiting;
  logic                  timed_out;

  assign idx       = cpu_addr[INDEX_BITS-1:0];
  assign tag       = cpu_addr[11:INDEX_BITS];
  assign hit       = valid[idx] && (tag_mem[idx] == tag);
  assign waiting   = (state == RD_MISS) || (state == WR_MEM);
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // The CPU holds address/data stable while stalled, so memory sees them directly.
  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || !waiting || (state_nxt != state)) wait_cnt <= '0;
    else                                         wait_cnt <= wait_cnt + 1'b1;
  end

  // A timed-out read completes with zero rather than stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state == RD_MISS) begin
      if (mem_ready)      rdata_q <= mem_rdata;
      else if (timed_out) rdata_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                valid      <= '0;
    else if (state == RD_MISS && mem_ready) valid[idx] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_ready) begin
      if (state == RD_MISS) begin
        tag_mem[idx]  <= tag;
        data_mem[idx] <= mem_rdata;
      end else if (state == WR_MEM && hit) begin
        data_mem[idx] <= cpu_wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    cpu_rdata = rdata_q;
    case (state)
      IDLE: begin
        if (cpu_w_en) begin
          stall     = 1'b1;
          state_nxt = WR_MEM;
        end else if (cpu_r_en) begin
          if (hit) begin
            cpu_rdata = data_mem[idx];
          end else begin
            stall     = 1'b1;
            state_nxt = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        stall    = 1'b1;
        mem_r_en = 1'b1;
        if (mem_ready || timed_out) state_nxt = DONE;
      end
      WR_MEM: begin
        stall    = 1'b1;
        mem_w_en = 1'b1;
        if (mem_ready || timed_out) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == IDLE) begin
      if (cpu_r_en && !cpu_w_en && hit && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (state_nxt == RD_MISS && miss_count != 16'hFFFF)
        miss_count <= miss_count + 16'd1;
    end
  end
`else
  assign hit_count  = 16'h0;
  assign miss_count = 16'h0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller against an abstract line/memory model.
module tb_cache_controller;

  localparam int TIMEOUT = 255;
`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_r_en = 1'b0;
  logic        cpu_w_en = 1'b0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  cache_controller #(.INDEX_BITS(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_r_en(cpu_r_en), .cpu_w_en(cpu_w_en),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: cache lines plus backing memory contents.
  bit          ref_valid [16];
  logic [7:0]  ref_tag   [16];
  logic [31:0] ref_data  [16];
  logic [31:0] mem_model [4096];
  int          hit_cnt = 0;
  int          miss_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_hits"},   {16'h0, hit_count},  STATS ? 32'(hit_cnt)  : 32'h0);
    chk({tag, "_misses"}, {16'h0, miss_count}, STATS ? 32'(miss_cnt) : 32'h0);
  endtask

  // lat = number of wait cycles before mem_ready is pulsed; 0 means never respond.
  task automatic do_req(input bit wr, input logic [11:0] addr, input logic [31:0] wd, input int lat);
    int          idx = int'(addr[3:0]);
    logic [7:0]  tg  = addr[11:4];
    bit          hit = ref_valid[idx] && (ref_tag[idx] == tg);
    int          stalls = 1;
    int          n = 0;
    bit          done = 1'b0;
    bit          resp_given = 1'b0;
    logic [31:0] resp = '0;
    @(negedge clk);
    mem_ready = 1'b0;
    cpu_addr  = addr;
    cpu_wdata = wd;
    cpu_r_en  = !wr;
    cpu_w_en  = wr;
    #1;
    if (!wr && hit) begin
      chk("hit_stall", {31'h0, stall}, 32'h0);
      chk("hit_rdata", cpu_rdata, ref_data[idx]);
      chk("hit_no_memrd", {31'h0, mem_r_en}, 32'h0);
      hit_cnt++;
    end else begin
      chk("req_stall", {31'h0, stall}, 32'h1);
      if (!wr) miss_cnt++;
      while (!done && n < 400) begin
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        if (!stall) begin
          done = 1'b1;
        end else begin
          stalls++;
          n++;
          if (n == 1) begin
            chk("mem_r_en", {31'h0, mem_r_en}, {31'h0, !wr});
            chk("mem_w_en", {31'h0, mem_w_en}, {31'h0, wr});
            chk("mem_addr", {20'h0, mem_addr}, {20'h0, addr});
            if (wr) chk("mem_wdata", mem_wdata, wd);
          end
          if (n == lat) begin
            resp       = wr ? 32'h0 : mem_model[addr];
            mem_rdata  = wr ? $urandom : resp;
            mem_ready  = 1'b1;
            resp_given = 1'b1;
          end
        end
      end
      chk("done_bound", {31'h0, done}, 32'h1);
      chk("stall_cycles", stalls, resp_given ? lat + 1 : TIMEOUT + 1);
      if (!wr) chk("done_rdata", cpu_rdata, resp_given ? resp : 32'h0);
      if (resp_given) begin
        if (wr) begin
          mem_model[addr] = wd;
          if (hit) ref_data[idx] = wd;
        end else begin
          ref_valid[idx] = 1'b1;
          ref_tag[idx]   = tg;
          ref_data[idx]  = resp;
        end
      end
    end
    @(posedge clk);
    #1;
    cpu_r_en = 1'b0;
    cpu_w_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem_model[i] = $urandom;
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    mem_model[12'h010] = 32'hDEADBEEF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_mem_r_en", {31'h0, mem_r_en}, 32'h0);
    chk("rst_mem_w_en", {31'h0, mem_w_en}, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk_stats("rst");

    // Stray completion pulse while idle must be ignored.
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("idle_ready_stall", {31'h0, stall}, 32'h0);
    chk("idle_ready_strobes", {30'h0, mem_r_en, mem_w_en}, 32'h0);
    @(negedge clk);
    mem_ready = 1'b0;

    do_req(1'b0, 12'h010, 32'h0, 3);
    chk_stats("first_miss");
    do_req(1'b0, 12'h010, 32'h0, 1);
    chk_stats("first_hit");
    do_req(1'b1, 12'h010, 32'h12345678, 2);
    do_req(1'b0, 12'h010, 32'h0, 1);
    do_req(1'b0, 12'h110, 32'h0, 1);
    do_req(1'b0, 12'h010, 32'h0, 2);
    do_req(1'b1, 12'h0A3, 32'hCAFEF00D, 1);
    do_req(1'b0, 12'h0A3, 32'h0, 4);
    chk_stats("directed");

    // Reset two cycles into a read miss, then a late mem_ready.
    @(negedge clk);
    cpu_addr = 12'h010;
    cpu_r_en = 1'b1;
    repeat (2) @(negedge clk);
    rst      = 1'b1;
    cpu_r_en = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h55AA55AA;
    #1;
    chk("midrst_stall", {31'h0, stall}, 32'h0);
    chk("midrst_strobes", {30'h0, mem_r_en, mem_w_en}, 32'h0);
    chk("midrst_rdata", cpu_rdata, 32'h0);
    for (int i = 0; i < 16; i++) ref_valid[i] = 1'b0;
    hit_cnt  = 0;
    miss_cnt = 0;
    @(negedge clk);
    mem_ready = 1'b0;
    chk_stats("midrst");
    do_req(1'b0, 12'h010, 32'h0, 2);

    // Memory never answers: abort after TIMEOUT, line stays invalid.
    do_req(1'b0, 12'h020, 32'h0, 0);
    do_req(1'b0, 12'h020, 32'h0, 1);
    do_req(1'b1, 12'h020, 32'h0BADF00D, 0);
    do_req(1'b0, 12'h020, 32'h0, 1);
    chk_stats("timeout");

    for (int k = 0; k < 60; k++) begin
      logic [11:0] a;
      a = {4'h0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
      do_req($urandom_range(0, 9) < 3, a, $urandom, $urandom_range(1, 4));
    end
    chk_stats("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
